// File: rtl/imem_dmem_arbiter.sv
// Round-robin arbiter sharing one memory port between the instruction fetcher (I)
// and the load/store unit (D). Only one memory transaction is in flight at a time.
module imem_dmem_arbiter #(
    parameter int bits       = 32,
    parameter bit RESET_LAST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [bits-1:0] i_addr,
    output logic            i_rdy,
    output logic            i_valid,
    output logic [bits-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [3:0]      d_be,
    input  logic [bits-1:0] d_addr,
    input  logic [bits-1:0] d_wdata,
    output logic            d_rdy,
    output logic            d_valid,
    output logic [bits-1:0] d_rdata,
    output logic            proc_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [bits-1:0] mem_addr,
    output logic [bits-1:0] mem_wdata,
    input  logic            mem_rdy,
    input  logic            valid,
    input  logic [bits-1:0] RDATA
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t          state_reg;
    owner_t          owner_reg;
    logic            last_reg;      // 1 = D was granted last
    logic [bits-1:0] i_rdata_reg;
    logic [bits-1:0] d_rdata_reg;
    logic            grant_i;
    logic            grant_d;
    logic            accept;
    logic            respond;

    // Grants are only decided in IDLE, so a completion never overlaps a new grant.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_reg == IDLE) begin
            if (i_req && d_req) begin
                grant_i = last_reg;
                grant_d = !last_reg;
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    assign accept  = (state_reg == REQ) && mem_rdy;
    assign respond = (state_reg == RESP) && valid;

    assign i_rdy   = accept  && (owner_reg == OWN_I);
    assign d_rdy   = accept  && (owner_reg == OWN_D);
    assign i_valid = respond && (owner_reg == OWN_I);
    assign d_valid = respond && (owner_reg == OWN_D);

    // Read data is forwarded in the valid cycle and held afterwards.
    assign i_rdata = i_valid ? RDATA : i_rdata_reg;
    assign d_rdata = d_valid ? RDATA : d_rdata_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            owner_reg   <= OWN_NONE;
            last_reg    <= RESET_LAST;
            proc_req    <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'b0000;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            if (i_valid) begin
                i_rdata_reg <= RDATA;
            end
            if (d_valid) begin
                d_rdata_reg <= RDATA;
            end
            case (state_reg)
                IDLE: begin
                    if (grant_i) begin
                        owner_reg <= OWN_I;
                        last_reg  <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                        proc_req  <= 1'b1;
                        state_reg <= REQ;
                    end else if (grant_d) begin
                        owner_reg <= OWN_D;
                        last_reg  <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_we    <= d_we;
                        mem_be    <= d_be;
                        mem_wdata <= d_wdata;
                        proc_req  <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (mem_rdy) begin
                        proc_req <= 1'b0;
                        if (mem_we) begin
                            // Writes complete on acceptance; no read data follows.
                            state_reg <= IDLE;
                            owner_reg <= OWN_NONE;
                        end else begin
                            state_reg <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (valid) begin
                        state_reg <= IDLE;
                        owner_reg <= OWN_NONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    owner_reg <= OWN_NONE;
                end
            endcase
        end
    end

endmodule
